ppu_requant: RTL

PPU_REQUANT -- requirements
Module: ppu_requant

---
 rtl/ppu_pkg.sv | 18 +
 rtl/requant_lane.sv | 85 ++++++++
 rtl/ppu_requant.sv | 99 +++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared defaults and requant configuration type for the PPU
package ppu_pkg;

  localparam int LANES_DEF   = 4;
  localparam int ACC_W_DEF   = 32;
  localparam int OUT_W_DEF   = 8;
  localparam int MULT_W_DEF  = 16;
  localparam int SHIFT_W_DEF = 5;

  // One requantisation setting, shared by every lane.
  typedef struct packed {
    logic [MULT_W_DEF-1:0]  mult;
    logic [SHIFT_W_DEF-1:0] shift;
    logic [OUT_W_DEF-1:0]   zp;
    logic                   relu;
  } requant_cfg_t;

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one lane of the requant datapath: relu/multiply, rounding shift, zero-point clamp
module requant_lane
  import ppu_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int MULT_W  = MULT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [ACC_W-1:0]   i_data,
  input  logic [MULT_W-1:0]  i_mult,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic [OUT_W-1:0]   i_zp,
  input  logic               i_relu,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_sat
);

  // Product width: one spare bit above the worst-case product leaves room
  // for the rounding term without overflow.
  localparam int P_W = ACC_W + MULT_W + 1;
  localparam logic signed [P_W:0] MAX_V = {{(P_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic signed [ACC_W-1:0] w_x;
  logic signed [P_W-1:0]   w_prod;
  logic signed [P_W-1:0]   w_round;
  logic signed [P_W-1:0]   w_shifted;
  logic signed [P_W:0]     w_sum;
  logic [OUT_W-1:0]        w_q;
  logic                    w_sat;

  logic signed [P_W-1:0]   r_p;
  logic signed [P_W-1:0]   r_s;
  logic [OUT_W-1:0]        r_q;
  logic                    r_sat;

  // S1: optional relu then signed x unsigned multiply.
  always_comb begin
    w_x    = (i_relu && i_data[ACC_W-1]) ? '0 : $signed(i_data);
    w_prod = $signed({{(P_W - ACC_W){w_x[ACC_W-1]}}, w_x}) *
             $signed({{(P_W - MULT_W){1'b0}}, i_mult});
  end

  // S2: round-half-up arithmetic right shift; shift of zero adds nothing.
  always_comb begin
    w_round   = (i_shift == '0) ? '0 : (P_W'(1) << (i_shift - SHIFT_W'(1)));
    w_shifted = (r_p + w_round) >>> i_shift;
  end

  // S3: add zero point and clamp into the unsigned output range.
  always_comb begin
    w_sum = $signed({r_s[P_W-1], r_s}) + $signed({{(P_W + 1 - OUT_W){1'b0}}, i_zp});
    w_q   = w_sum[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_sum[P_W]) begin
      w_q   = '0;
      w_sat = 1'b1;
    end else if (w_sum > MAX_V) begin
      w_q   = '1;
      w_sat = 1'b1;
    end
  end

  // Pipeline registers advance only on the shared enable (global stall).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p   <= '0;
      r_s   <= '0;
      r_q   <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_p   <= w_prod;
      r_s   <= w_shifted;
      r_q   <= w_q;
      r_sat <= w_sat;
    end
  end

  assign o_data = r_q;
  assign o_sat  = r_sat;

endmodule

// File: rtl/ppu_requant.sv
// rtl/ppu_requant.sv - multi-lane requantisation pipeline with handshake, config and saturation count
module ppu_requant
  import ppu_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int MULT_W  = MULT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [MULT_W-1:0]      cfg_mult,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic [OUT_W-1:0]       cfg_zp,
  input  logic                   cfg_relu,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   busy,
  output logic [15:0]            sat_cnt
);

  logic         r_v1;
  logic         r_v2;
  logic         r_v3;
  requant_cfg_t r_cfg;
  logic [15:0]  r_sat_cnt;

  logic             w_adv;
  logic             w_cfg_acc;
  logic             w_out_fire;
  logic [LANES-1:0] w_sat;

  assign w_adv      = !r_v3 || out_ready;
  assign in_ready   = w_adv;
  assign out_valid  = r_v3;
  assign busy       = r_v1 || r_v2 || r_v3;
  assign w_cfg_acc  = cfg_we && !busy && !in_valid;
  assign w_out_fire = r_v3 && out_ready;
  assign sat_cnt    = r_sat_cnt;

  // Stage valid bits move together with the lane datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Configuration only changes while the pipeline is empty and idle,
  // so every stage can read the live register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg <= '{mult: MULT_W_DEF'(1), shift: '0, zp: '0, relu: 1'b1};
    end else if (w_cfg_acc) begin
      r_cfg <= '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp, relu: cfg_relu};
    end
  end

  // Count delivered beats with any saturated lane; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || w_cfg_acc) begin
      r_sat_cnt <= '0;
    end else if (w_out_fire && (|w_sat) && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .MULT_W  (MULT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_data  (in_data[g*ACC_W +: ACC_W]),
      .i_mult  (r_cfg.mult),
      .i_shift (r_cfg.shift),
      .i_zp    (r_cfg.zp),
      .i_relu  (r_cfg.relu),
      .o_data  (out_data[g*OUT_W +: OUT_W]),
      .o_sat   (w_sat[g])
    );
  end

endmodule
